// File: rtl/intr_gateway_arb.sv
// Interrupt gateway and priority arbiter for one CPU target.
// Each source has a level-sensitive gateway (IDLE/PEND/INSVC). A registered
// arbiter picks the highest-priority enabled pending source. A claim/complete
// handshake moves sources into and out of service.
module intr_gateway_arb #(
  parameter int unsigned NumSrc = 8,
  parameter int unsigned PrioW  = 2,
  localparam int unsigned IdW   = $clog2(NumSrc + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumSrc-1:0]       intr_src_i,
  input  logic [NumSrc*PrioW-1:0] prio_i,
  input  logic [NumSrc-1:0]       ie_i,
  input  logic [PrioW-1:0]        threshold_i,
  input  logic                    claim_req_i,
  output logic                    claim_valid_o,
  output logic [IdW-1:0]          claim_id_o,
  input  logic                    complete_req_i,
  input  logic [IdW-1:0]          complete_id_i,
  output logic [NumSrc-1:0]       ip_o,
  output logic                    irq_o,
  output logic [IdW-1:0]          irq_id_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PEND  = 2'd1;
  localparam logic [1:0] ST_INSVC = 2'd2;

  logic [NumSrc-1:0][1:0] gw_q;
  logic [NumSrc-1:0][1:0] gw_d;
  logic [NumSrc-1:0]      claim_hit;
  logic                   claim_ok;
  logic [PrioW-1:0]       best_prio;
  logic [IdW-1:0]         best_id;

  // A claim succeeds only if the registered winner is above threshold and still pending
  always_comb begin
    claim_hit = '0;
    for (int unsigned i = 0; i < NumSrc; i++) begin
      claim_hit[i] = claim_req_i && irq_o && (irq_id_o == IdW'(i + 1)) &&
                     (gw_q[i] == ST_PEND);
    end
  end

  assign claim_ok = |claim_hit;

  // Gateway next-state; completes only match an in-service source with the same ID
  always_comb begin
    gw_d = gw_q;
    for (int unsigned i = 0; i < NumSrc; i++) begin
      case (gw_q[i])
        ST_IDLE:  if (intr_src_i[i]) gw_d[i] = ST_PEND;
        ST_PEND:  if (claim_hit[i]) gw_d[i] = ST_INSVC;
        ST_INSVC: if (complete_req_i && (complete_id_i == IdW'(i + 1))) gw_d[i] = ST_IDLE;
        default:  gw_d[i] = ST_IDLE;
      endcase
    end
  end

  // Arbitration over registered gateway state; strict compare keeps the lowest ID on ties
  always_comb begin
    best_prio = '0;
    best_id   = '0;
    for (int unsigned i = 0; i < NumSrc; i++) begin
      if ((gw_q[i] == ST_PEND) && ie_i[i] && (prio_i[i*PrioW +: PrioW] > best_prio)) begin
        best_prio = prio_i[i*PrioW +: PrioW];
        best_id   = IdW'(i + 1);
      end
    end
  end

  // Pending bits are a direct decode of the gateway state flops
  always_comb begin
    ip_o = '0;
    for (int unsigned i = 0; i < NumSrc; i++) begin
      ip_o[i] = (gw_q[i] == ST_PEND);
    end
  end

  // Gateway state, arbiter result and claim response registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gw_q          <= '0;
      irq_o         <= 1'b0;
      irq_id_o      <= '0;
      claim_valid_o <= 1'b0;
      claim_id_o    <= '0;
    end else begin
      gw_q          <= gw_d;
      irq_id_o      <= best_id;
      irq_o         <= (best_id != '0) && (best_prio > threshold_i);
      claim_valid_o <= claim_req_i;
      if (claim_req_i) begin
        claim_id_o <= claim_ok ? irq_id_o : '0;
      end
    end
  end

endmodule

// File: tb/tb_intr_gateway_arb.sv
// Directed, self-checking bench for intr_gateway_arb.
module tb_intr_gateway_arb;

  logic        clk_i;
  logic        rst_i;
  logic [7:0]  intr_src_i;
  logic [15:0] prio_i;
  logic [7:0]  ie_i;
  logic [1:0]  threshold_i;
  logic        claim_req_i;
  logic        claim_valid_o;
  logic [3:0]  claim_id_o;
  logic        complete_req_i;
  logic [3:0]  complete_id_i;
  logic [7:0]  ip_o;
  logic        irq_o;
  logic [3:0]  irq_id_o;

  int n_cmp = 0;
  int n_err = 0;

  intr_gateway_arb dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .intr_src_i     (intr_src_i),
    .prio_i         (prio_i),
    .ie_i           (ie_i),
    .threshold_i    (threshold_i),
    .claim_req_i    (claim_req_i),
    .claim_valid_o  (claim_valid_o),
    .claim_id_o     (claim_id_o),
    .complete_req_i (complete_req_i),
    .complete_id_i  (complete_id_i),
    .ip_o           (ip_o),
    .irq_o          (irq_o),
    .irq_id_o       (irq_id_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0]  src;
    logic [15:0] prio;
    logic [7:0]  ie;
    logic [1:0]  thr;
    logic        claim;
    logic        cmpl;
    logic [3:0]  cmpl_id;
    logic [7:0]  e_ip;
    logic        e_irq;
    logic [3:0]  e_id;
    logic        e_cv;
    logic [3:0]  e_cid;
  } vec_t;

  vec_t tbl [11];

  function automatic logic [15:0] pr(input int k, input logic [1:0] p);
    logic [15:0] v;
    v = 16'(p) << (2 * (k - 1));
    return v;
  endfunction

  function automatic vec_t mkv(input logic [7:0] src, input logic [15:0] prio,
                               input logic [7:0] ie, input logic [1:0] thr,
                               input logic claim, input logic cmpl, input logic [3:0] cmpl_id,
                               input logic [7:0] e_ip, input logic e_irq, input logic [3:0] e_id,
                               input logic e_cv, input logic [3:0] e_cid);
    vec_t v;
    v.src = src; v.prio = prio; v.ie = ie; v.thr = thr;
    v.claim = claim; v.cmpl = cmpl; v.cmpl_id = cmpl_id;
    v.e_ip = e_ip; v.e_irq = e_irq; v.e_id = e_id; v.e_cv = e_cv; v.e_cid = e_cid;
    return v;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_ip, input logic e_irq,
                         input logic [3:0] e_id, input logic e_cv, input logic [3:0] e_cid);
    chk({tag, ".ip"},  32'(ip_o),          32'(e_ip));
    chk({tag, ".irq"}, 32'(irq_o),         32'(e_irq));
    chk({tag, ".id"},  32'(irq_id_o),      32'(e_id));
    chk({tag, ".cv"},  32'(claim_valid_o), 32'(e_cv));
    chk({tag, ".cid"}, 32'(claim_id_o),    32'(e_cid));
  endtask

  task automatic idle_inputs();
    intr_src_i = '0; prio_i = '0; ie_i = 8'hFF; threshold_i = '0;
    claim_req_i = 1'b0; complete_req_i = 1'b0; complete_id_i = '0;
  endtask

  task automatic do_reset(input string tag);
    idle_inputs();
    rst_i = 1'b1;
    step();
    chk_all(tag, 8'h00, 1'b0, 4'd0, 1'b0, 4'd0);
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    idle_inputs();

    // Reset and single source latency
    #3;
    chk_all("rst0", 8'h00, 1'b0, 4'd0, 1'b0, 4'd0);
    intr_src_i = 8'h04; prio_i = pr(3, 2'd2);
    step();
    chk_all("rst_edge", 8'h00, 1'b0, 4'd0, 1'b0, 4'd0);
    rst_i = 1'b0;
    step();
    chk_all("single_n", 8'h04, 1'b0, 4'd0, 1'b0, 4'd0);
    step();
    chk_all("single_n1", 8'h04, 1'b1, 4'd3, 1'b0, 4'd0);

    // Priority, tie, threshold, enable, claim and complete with re-pend
    tbl[0]  = mkv(8'h12, pr(2,1)|pr(5,1), 8'hFF, 2'd0, 0, 0, 4'd0, 8'h12, 0, 4'd0, 0, 4'd0);
    tbl[1]  = mkv(8'h12, pr(2,1)|pr(5,1), 8'hFF, 2'd0, 0, 0, 4'd0, 8'h12, 1, 4'd2, 0, 4'd0);
    tbl[2]  = mkv(8'h12, pr(2,1)|pr(5,3), 8'hFF, 2'd0, 0, 0, 4'd0, 8'h12, 1, 4'd5, 0, 4'd0);
    tbl[3]  = mkv(8'h12, pr(2,1)|pr(5,3), 8'hFF, 2'd3, 0, 0, 4'd0, 8'h12, 0, 4'd5, 0, 4'd0);
    tbl[4]  = mkv(8'h12, pr(2,1)|pr(5,3), 8'hEF, 2'd3, 0, 0, 4'd0, 8'h12, 0, 4'd2, 0, 4'd0);
    tbl[5]  = mkv(8'h12, pr(2,1)|pr(5,3), 8'hFF, 2'd0, 0, 0, 4'd0, 8'h12, 1, 4'd5, 0, 4'd0);
    tbl[6]  = mkv(8'h12, pr(2,1)|pr(5,3), 8'hFF, 2'd0, 1, 0, 4'd0, 8'h02, 1, 4'd5, 1, 4'd5);
    tbl[7]  = mkv(8'h12, pr(2,1)|pr(5,3), 8'hFF, 2'd0, 0, 0, 4'd0, 8'h02, 1, 4'd2, 0, 4'd5);
    tbl[8]  = mkv(8'h12, pr(2,1)|pr(5,3), 8'hFF, 2'd0, 0, 1, 4'd5, 8'h02, 1, 4'd2, 0, 4'd5);
    tbl[9]  = mkv(8'h12, pr(2,1)|pr(5,3), 8'hFF, 2'd0, 0, 0, 4'd0, 8'h12, 1, 4'd2, 0, 4'd5);
    tbl[10] = mkv(8'h12, pr(2,1)|pr(5,3), 8'hFF, 2'd0, 0, 0, 4'd0, 8'h12, 1, 4'd5, 0, 4'd5);

    do_reset("rst_tbl");
    for (int i = 0; i < 11; i++) begin
      intr_src_i = tbl[i].src; prio_i = tbl[i].prio; ie_i = tbl[i].ie;
      threshold_i = tbl[i].thr; claim_req_i = tbl[i].claim;
      complete_req_i = tbl[i].cmpl; complete_id_i = tbl[i].cmpl_id;
      step();
      chk_all($sformatf("tbl%0d", i), tbl[i].e_ip, tbl[i].e_irq, tbl[i].e_id,
              tbl[i].e_cv, tbl[i].e_cid);
    end

    // Back-to-back claims: second sees a stale winner and returns 0
    do_reset("rst_b2b");
    intr_src_i = 8'h09; prio_i = pr(1,1) | pr(4,2);
    step();
    chk_all("b2b_pend", 8'h09, 1'b0, 4'd0, 1'b0, 4'd0);
    step();
    chk_all("b2b_arb", 8'h09, 1'b1, 4'd4, 1'b0, 4'd0);
    claim_req_i = 1'b1;
    step();
    chk_all("b2b_c1", 8'h01, 1'b1, 4'd4, 1'b1, 4'd4);
    step();
    chk_all("b2b_c2", 8'h01, 1'b1, 4'd1, 1'b1, 4'd0);
    claim_req_i = 1'b0;
    step();
    chk_all("b2b_gap", 8'h01, 1'b1, 4'd1, 1'b0, 4'd0);
    claim_req_i = 1'b1;
    step();
    chk_all("b2b_c3", 8'h00, 1'b1, 4'd1, 1'b1, 4'd1);
    claim_req_i = 1'b0;

    // Bad completes leave in-service sources alone; the valid one re-pends src4
    complete_req_i = 1'b1;
    complete_id_i = 4'd0;
    step(); step();
    chk_all("bad_id0", 8'h00, 1'b0, 4'd0, 1'b0, 4'd1);
    complete_id_i = 4'd9;
    step(); step();
    chk_all("bad_id9", 8'h00, 1'b0, 4'd0, 1'b0, 4'd1);
    complete_id_i = 4'd2;
    step(); step();
    chk_all("bad_idle", 8'h00, 1'b0, 4'd0, 1'b0, 4'd1);
    complete_id_i = 4'd4;
    step();
    chk_all("cmpl4_a", 8'h00, 1'b0, 4'd0, 1'b0, 4'd1);
    step();
    chk_all("cmpl4_b", 8'h08, 1'b0, 4'd0, 1'b0, 4'd1);
    complete_req_i = 1'b0; complete_id_i = 4'd0;
    step();
    chk_all("repend4", 8'h08, 1'b1, 4'd4, 1'b0, 4'd1);

    // Reset asserted mid-cycle while src1 is in service
    do_reset("rst_mid0");
    intr_src_i = 8'h01; prio_i = pr(1,1);
    step(); step();
    chk_all("mid_arb", 8'h01, 1'b1, 4'd1, 1'b0, 4'd0);
    claim_req_i = 1'b1;
    step();
    chk_all("mid_claim", 8'h00, 1'b1, 4'd1, 1'b1, 4'd1);
    claim_req_i = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    chk_all("mid_rst", 8'h00, 1'b0, 4'd0, 1'b0, 4'd0);
    step();
    rst_i = 1'b0;
    step();
    chk_all("mid_rel", 8'h01, 1'b0, 4'd0, 1'b0, 4'd0);
    step();
    chk_all("mid_rel1", 8'h01, 1'b1, 4'd1, 1'b0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
